// File: rtl/palindrome_pkg.sv
// Shared types for the streaming palindrome detector.
// Holds the control FSM state encoding.
package palindrome_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    CHECK  = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/palindrome_buf.sv
// Symbol store: one write port, two async read ports.
// Contents are don't-care until written, so no reset.
module palindrome_buf
  import palindrome_pkg::*;
#(
  parameter int SYM_WIDTH = 8,
  parameter int MAX_LEN   = 16,
  parameter int AW        = $clog2(MAX_LEN)
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [AW-1:0]        i_waddr,
  input  logic [SYM_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]        i_lo,
  input  logic [AW-1:0]        i_hi,
  output logic [SYM_WIDTH-1:0] o_lo,
  output logic [SYM_WIDTH-1:0] o_hi
);

  logic [SYM_WIDTH-1:0] r_mem [MAX_LEN];

  // Store an accepted symbol at the fill index
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_lo = r_mem[i_lo];
  assign o_hi = r_mem[i_hi];

endmodule

// File: rtl/palindrome_stream_detect.sv
// Streaming palindrome detector: fill, check pairwise, report.
// One sequence in flight; results held until consumed.
module palindrome_stream_detect
  import palindrome_pkg::*;
#(
  parameter int SYM_WIDTH = 8,
  parameter int MAX_LEN   = 16,
  parameter int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SYM_WIDTH-1:0] din,
  input  logic                 din_valid,
  input  logic                 din_last,
  output logic                 din_ready,
  output logic                 dout,
  output logic [LEN_W-1:0]     dout_len,
  output logic                 dout_overflow,
  output logic                 dout_valid,
  input  logic                 dout_ready
);

  localparam int AW = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] LMAX = LEN_W'(MAX_LEN);

  state_t             r_state, n_state;
  logic [LEN_W-1:0]   r_count, n_count;
  logic [AW-1:0]      r_lo, n_lo;
  logic [AW-1:0]      r_hi, n_hi;
  logic               r_ovf, n_ovf;
  logic               r_dout, n_dout;

  logic               w_accept;
  logic               w_store;
  logic [SYM_WIDTH-1:0] w_sym_lo;
  logic [SYM_WIDTH-1:0] w_sym_hi;

  assign din_ready     = (r_state == FILL);
  assign dout_valid    = (r_state == REPORT);
  assign dout          = r_dout;
  assign dout_len      = r_count;
  assign dout_overflow = r_ovf;

  assign w_accept = din_valid && din_ready;
  assign w_store  = w_accept && (r_count < LMAX);

  palindrome_buf #(
    .SYM_WIDTH (SYM_WIDTH),
    .MAX_LEN   (MAX_LEN),
    .AW        (AW)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_store),
    .i_waddr (r_count[AW-1:0]),
    .i_wdata (din),
    .i_lo    (r_lo),
    .i_hi    (r_hi),
    .o_lo    (w_sym_lo),
    .o_hi    (w_sym_hi)
  );

  // State, counters and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FILL;
      r_count <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_ovf   <= 1'b0;
      r_dout  <= 1'b0;
    end else begin
      r_state <= n_state;
      r_count <= n_count;
      r_lo    <= n_lo;
      r_hi    <= n_hi;
      r_ovf   <= n_ovf;
      r_dout  <= n_dout;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    n_state = r_state;
    n_count = r_count;
    n_lo    = r_lo;
    n_hi    = r_hi;
    n_ovf   = r_ovf;
    n_dout  = r_dout;
    unique case (r_state)
      FILL: begin
        if (w_accept) begin
          if (w_store) n_count = r_count + LEN_W'(1);
          else         n_ovf   = 1'b1;
          if (din_last) begin
            if (r_ovf || !w_store) begin
              n_state = REPORT;
              n_dout  = 1'b0;
            end else begin
              n_state = CHECK;
              n_lo    = '0;
              n_hi    = r_count[AW-1:0];
            end
          end
        end
      end
      CHECK: begin
        if (r_lo >= r_hi) begin
          n_state = REPORT;
          n_dout  = 1'b1;
        end else if (w_sym_lo != w_sym_hi) begin
          n_state = REPORT;
          n_dout  = 1'b0;
        end else begin
          n_lo = r_lo + AW'(1);
          n_hi = r_hi - AW'(1);
        end
      end
      REPORT: begin
        if (dout_ready) begin
          n_state = FILL;
          n_count = '0;
          n_lo    = '0;
          n_hi    = '0;
          n_ovf   = 1'b0;
        end
      end
      default: n_state = FILL;
    endcase
  end

endmodule

// File: doc/palindrome_stream_detect.md
# palindrome_stream_detect

Streaming successor to the combinational palindrome detector. Instead of checking one fixed-width word in a single cycle, it accepts a variable-length sequence of symbols over a valid/ready stream, buffers up to `MAX_LEN` symbols, and then checks them pair by pair. It returns the verdict, the sequence length and an overflow flag on a valid/ready result port. It sits between a symbol source (parser/deserialiser) and a consumer that needs a per-packet palindrome verdict.

## Interface
- `SYM_WIDTH`, 8, bits per symbol (>=1)
- `MAX_LEN`, 16, maximum stored symbols per sequence (>=2)
- `LEN_W`, `$clog2(MAX_LEN+1)`, derived length width; not overridden
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `din`  in  `SYM_WIDTH`  input symbol
- `din_valid`  in  1  symbol present
- `din_last`  in  1  qualifies `din`: final symbol of sequence
- `din_ready`  out  1  block accepts a symbol this cycle
- `dout`  out  1  1 = sequence is a palindrome
- `dout_len`  out  `LEN_W`  symbols stored (saturates at `MAX_LEN`)
- `dout_overflow`  out  1  sequence exceeded `MAX_LEN`
- `dout_valid`  out  1  result present
- `dout_ready`  in  1  consumer takes result

## Operation
- FSM states: FILL (reset state), CHECK, REPORT. `din_ready` = (state==FILL). `dout_valid` = (state==REPORT).
- FILL: each accepted symbol (`din_valid && din_ready`) is written at index `count`, then `count` increments. Gaps in `din_valid` are allowed.
  - If `count==MAX_LEN`, further symbols are dropped and the overflow flag is set. Acceptance continues until `din_last`.
  - An accepted `din_last` symbol is stored under the same rule as any other symbol.
  - On `din_last`: with overflow, go to REPORT with `dout=0`. Otherwise go to CHECK with `lo=0` and `hi=count_next-1`.
- CHECK, once per cycle:
  - If `lo>=hi`: result 1, go to REPORT.
  - Else if `buf[lo]!=buf[hi]`: result 0, go to REPORT.
  - Else `lo++`, `hi--`.
- REPORT: `dout`, `dout_len` and `dout_overflow` stay stable while `dout_valid && !dout_ready`. On handshake, go to FILL and clear `count`, `lo`, `hi` and the overflow flag.
- A length-1 sequence is a palindrome. A sequence can never be empty, because `last` always carries a symbol.
- Reset (async): state goes to FILL and the partial sequence is discarded. Buffer contents need no reset.
  - Reset values: `din_ready=1`, `dout_valid=0`, `dout=0`, `dout_len=0`, `dout_overflow=0`.

## Timing
- Let E be the clock edge that accepts the `din_last` symbol, and L the stored length.
- Palindrome, no overflow: `dout_valid` is high after edge E+floor(L/2)+1.
- First mismatch at pair index k (0-based): `dout_valid` is high after edge E+1+k.
- Overflow: `dout_valid` is high after edge E, so CHECK is skipped.
- `din_ready` is low from after edge E until after the REPORT handshake edge. At most one sequence is in flight.
- Result outputs are registered, with no combinational path from `din` to `dout*`. `din_ready` depends only on state.
- A `dout_ready` held high in REPORT completes the handshake on the first REPORT edge. FILL resumes on the next cycle.

## Structure
- Package `palindrome_pkg` holds the `state_t` enum (FILL, CHECK, REPORT).
- Sub-module `palindrome_buf`: a `MAX_LEN` x `SYM_WIDTH` register array with one write port and two asynchronous read ports (`lo`, `hi`). Parameters are `SYM_WIDTH` and `MAX_LEN`.
- The top level contains the FSM, the counters and the result registers.

## Test plan
Default parameters (8, 16), `dout_ready=1` unless stated otherwise.
1. Back-to-back 0x41,0x42,0x43,0x42,0x41 (last on 5th) -> `dout=1`, `dout_len=5`, `dout_overflow=0`, `dout_valid` after E+3.
2. 0x10,0x20,0x30,0x40 -> `dout=0`, `dout_len=4`, `dout_valid` after E+1 (mismatch at pair 0); 0x01,0x02,0x03,0x01 -> `dout=0` after E+2.
3. Single 0xFF with last -> `dout=1`, `dout_len=1`, `dout_valid` after E+1; 0x5A,0x5A -> `dout=1`, `dout_len=2` after E+2.
4. 17 symbols of 0x00 -> `dout_overflow=1`, `dout=0`, `dout_len=16`, `dout_valid` after E; the next sequence 0x07 -> `dout=1`, `dout_overflow=0`.
5. Palindrome 0x11,0x22,0x11 sent with `din_valid` gaps, then `dout_ready=0` for 5 cycles:
   - outputs stable, `din_ready=0` throughout;
   - after the handshake, `din_ready=1` next cycle and a new sequence is accepted.
6. Reset asserted asynchronously after 3 symbols of a sequence:
   - outputs take reset values immediately;
   - after release, 0xAA,0xAA -> `dout=1`, `dout_len=2` (no residue from the aborted sequence).
